// File: rtl/textlcd_pkg.sv
// Shared constants, state encodings and helpers for the 2x16 text LCD driver.
package textlcd_pkg;

  localparam logic [7:0] FUNC_SET    = 8'h38;
  localparam logic [7:0] DISP_ON     = 8'h0C;
  localparam logic [7:0] ENTRY_MODE  = 8'h06;
  localparam logic [7:0] CLEAR       = 8'h01;
  localparam logic [7:0] LINE1_ADDR  = 8'h80;
  localparam logic [7:0] LINE2_ADDR  = 8'hC0;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, SNAP, ADDR1, LINE1, ADDR2, LINE2, DIFF_IDLE
  } lcd_state_t;

  typedef enum logic [2:0] {
    WR_IDLE, WR_SETUP, WR_E_HIGH, WR_HOLD, WR_WAIT
  } wr_phase_t;

  // Power-on command list, indexed by init step.
  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    case (step)
      2'd0:    return FUNC_SET;
      2'd1:    return DISP_ON;
      2'd2:    return ENTRY_MODE;
      default: return CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// One HD44780 bus write: setup, E pulse, hold, then the command-dependent post-wait.
module lcd_byte_writer
  import textlcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned E_HIGH_CYC     = 12,
  parameter int unsigned HOLD_CYC       = 2,
  parameter int unsigned CMD_WAIT_CYC   = 1000,
  parameter int unsigned CLEAR_WAIT_CYC = 41000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       rs_in,
  input  logic [7:0] data_in,
  input  logic       long_wait,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       done
);

  localparam int unsigned MAX_WAIT = (CLEAR_WAIT_CYC > CMD_WAIT_CYC) ? CLEAR_WAIT_CYC : CMD_WAIT_CYC;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_LD     = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  // The cycle in which the sequencer's registered start arrives is the final
  // post-wait cycle, so the internal wait runs one short and writes stay back-to-back.
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 2);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_WAIT_CYC - 2);

  wr_phase_t        phase;
  logic [CNT_W-1:0] cnt;
  logic             long_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase    <= WR_IDLE;
      cnt      <= '0;
      long_q   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (phase)
        WR_IDLE: if (start) begin
          lcd_rs   <= rs_in;
          lcd_data <= data_in;
          long_q   <= long_wait;
          cnt      <= SETUP_LD;
          phase    <= WR_SETUP;
        end
        WR_SETUP: if (cnt == '0) begin
          lcd_e <= 1'b1;
          cnt   <= E_LD;
          phase <= WR_E_HIGH;
        end else cnt <= cnt - 1'b1;
        WR_E_HIGH: if (cnt == '0) begin
          lcd_e <= 1'b0;
          cnt   <= HOLD_LD;
          phase <= WR_HOLD;
        end else cnt <= cnt - 1'b1;
        WR_HOLD: if (cnt == '0) begin
          cnt   <= long_q ? CLEAR_LD : CMD_LD;
          done  <= long_q ? (CLEAR_LD == '0) : (CMD_LD == '0);
          phase <= WR_WAIT;
        end else cnt <= cnt - 1'b1;
        WR_WAIT: if (cnt == '0) begin
          phase <= WR_IDLE;
        end else begin
          cnt  <= cnt - 1'b1;
          done <= (cnt == CNT_W'(1));
        end
        default: phase <= WR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/textlcd_driver.sv
// 2x16 character LCD driver: power-on init, then continuous refresh of a snapshot of textdata_a..h.
// Optional macro TEXTLCD_DIFF_UPDATE_EN skips frames identical to the last one written.
module textlcd_driver
  import textlcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYC    = 375000,
  parameter int unsigned CMD_WAIT_CYC   = 1000,
  parameter int unsigned CLEAR_WAIT_CYC = 41000,
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned E_HIGH_CYC     = 12,
  parameter int unsigned HOLD_CYC       = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] textdata_a,
  input  logic [31:0] textdata_b,
  input  logic [31:0] textdata_c,
  input  logic [31:0] textdata_d,
  input  logic [31:0] textdata_e,
  input  logic [31:0] textdata_f,
  input  logic [31:0] textdata_g,
  input  logic [31:0] textdata_h,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data,
  output logic        init_done,
  output logic        frame_done
);

  localparam int unsigned WAIT_MAX = (POWERUP_CYC > CMD_WAIT_CYC) ? POWERUP_CYC : CMD_WAIT_CYC;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX) + 1;
  localparam logic [WAIT_W-1:0] PWR_LAST = WAIT_W'(POWERUP_CYC - 1);

  lcd_state_t        state;
  logic [1:0]        step;
  logic [3:0]        idx;
  logic [3:0]        idx_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [15:0][7:0]  text_l1, text_l2;
  logic [15:0][7:0]  snap_l1, snap_l2;
  logic              wr_start, wr_rs, wr_done;
  logic [7:0]        wr_data;

  // Element 15 is the leftmost character, so char index i selects element ~i.
  assign text_l1 = {textdata_a, textdata_b, textdata_c, textdata_d};
  assign text_l2 = {textdata_e, textdata_f, textdata_g, textdata_h};
  assign idx_nxt = idx + 4'd1;
  assign lcd_rw  = 1'b0;

`ifdef TEXTLCD_DIFF_UPDATE_EN
  localparam logic [WAIT_W-1:0] IDLE_LAST = WAIT_W'(CMD_WAIT_CYC - 1);
  logic [15:0][7:0] last_l1, last_l2;
  logic             last_valid;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= PWR_WAIT;
      step       <= 2'd0;
      idx        <= 4'd0;
      wait_cnt   <= '0;
      snap_l1    <= {16{ASCII_SPACE}};
      snap_l2    <= {16{ASCII_SPACE}};
      wr_start   <= 1'b0;
      wr_rs      <= 1'b0;
      wr_data    <= 8'h00;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
`ifdef TEXTLCD_DIFF_UPDATE_EN
      last_l1    <= {16{ASCII_SPACE}};
      last_l2    <= {16{ASCII_SPACE}};
      last_valid <= 1'b0;
`endif
    end else begin
      wr_start   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        PWR_WAIT: if (wait_cnt == PWR_LAST) begin
          state    <= INIT;
          step     <= 2'd0;
          wr_start <= 1'b1;
          wr_rs    <= 1'b0;
          wr_data  <= init_cmd(2'd0);
        end else wait_cnt <= wait_cnt + 1'b1;
        INIT: if (wr_done) begin
          if (step == 2'd3) begin
            init_done <= 1'b1;
            state     <= SNAP;
`ifndef TEXTLCD_DIFF_UPDATE_EN
            wr_start  <= 1'b1;
            wr_rs     <= 1'b0;
            wr_data   <= LINE1_ADDR;
`endif
          end else begin
            step     <= step + 2'd1;
            wr_start <= 1'b1;
            wr_rs    <= 1'b0;
            wr_data  <= init_cmd(step + 2'd1);
          end
        end
        SNAP: begin
          snap_l1 <= text_l1;
          snap_l2 <= text_l2;
`ifdef TEXTLCD_DIFF_UPDATE_EN
          if (last_valid && text_l1 == last_l1 && text_l2 == last_l2) begin
            state    <= DIFF_IDLE;
            wait_cnt <= '0;
          end else begin
            state    <= ADDR1;
            wr_start <= 1'b1;
            wr_rs    <= 1'b0;
            wr_data  <= LINE1_ADDR;
          end
`else
          state <= ADDR1;
`endif
        end
        ADDR1: if (wr_done) begin
          state    <= LINE1;
          idx      <= 4'd0;
          wr_start <= 1'b1;
          wr_rs    <= 1'b1;
          wr_data  <= snap_l1[15];
        end
        LINE1: if (wr_done) begin
          idx      <= idx_nxt;
          wr_start <= 1'b1;
          if (idx == 4'd15) begin
            state   <= ADDR2;
            wr_rs   <= 1'b0;
            wr_data <= LINE2_ADDR;
          end else begin
            wr_rs   <= 1'b1;
            wr_data <= snap_l1[~idx_nxt];
          end
        end
        ADDR2: if (wr_done) begin
          state    <= LINE2;
          idx      <= 4'd0;
          wr_start <= 1'b1;
          wr_rs    <= 1'b1;
          wr_data  <= snap_l2[15];
        end
        LINE2: if (wr_done) begin
          idx <= idx_nxt;
          if (idx == 4'd15) begin
            frame_done <= 1'b1;
            state      <= SNAP;
`ifdef TEXTLCD_DIFF_UPDATE_EN
            last_l1    <= snap_l1;
            last_l2    <= snap_l2;
            last_valid <= 1'b1;
`else
            wr_start   <= 1'b1;
            wr_rs      <= 1'b0;
            wr_data    <= LINE1_ADDR;
`endif
          end else begin
            wr_start <= 1'b1;
            wr_rs    <= 1'b1;
            wr_data  <= snap_l2[~idx_nxt];
          end
        end
        DIFF_IDLE: begin
`ifdef TEXTLCD_DIFF_UPDATE_EN
          if (wait_cnt == IDLE_LAST) state <= SNAP;
          else wait_cnt <= wait_cnt + 1'b1;
`else
          state <= PWR_WAIT;
`endif
        end
        default: state <= PWR_WAIT;
      endcase
    end
  end

  lcd_byte_writer #(
    .SETUP_CYC      (SETUP_CYC),
    .E_HIGH_CYC     (E_HIGH_CYC),
    .HOLD_CYC       (HOLD_CYC),
    .CMD_WAIT_CYC   (CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
  ) u_writer (
    .clk       (clk),
    .resetn    (resetn),
    .start     (wr_start),
    .rs_in     (wr_rs),
    .data_in   (wr_data),
    .long_wait (!wr_rs && wr_data == CLEAR),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_data  (lcd_data),
    .done      (wr_done)
  );

endmodule
